// File: rtl/sc_denorm.sv
// Stochastic-to-binary de-normalizer: counts ones over a 2^STREAM_LOG-bit stream and
// rescales the count by the normalizer shift code, with a saturating valid/ready output.
module sc_denorm #(
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT_W    = $clog2(DATA_WIDTH),
  parameter int K          = 4,
  parameter int STREAM_LOG = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SHIFT_W-1:0]    shift_in,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  overflow,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W  = STREAM_LOG + 1;
  localparam int WIDE_W = CNT_W + (1 << SHIFT_W);

  localparam logic [SHIFT_W-1:0] FLOOR_CODE = SHIFT_W'(K - 1);
  localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'((1 << STREAM_LOG) - 1);
  localparam logic [WIDE_W-1:0]  MAX_OUT    = WIDE_W'((1 << DATA_WIDTH) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SCALE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SHIFT_W-1:0]      code_q, code_d;
  logic [CNT_W-1:0]        ones_q, ones_d;
  logic [CNT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    ovf_q, ovf_d;
  logic [SHIFT_W:0]        shamt_s;
  logic [WIDE_W-1:0]       wide_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM; else state_d = S_IDLE;
      S_ACCUM: if (bit_valid && (bit_q == LAST_BIT)) state_d = S_SCALE; else state_d = S_ACCUM;
      S_SCALE: state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = S_IDLE; else state_d = S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end

  // shift+1 can reach 2^SHIFT_W, so the amount and the product are kept wide enough
  always_comb begin
    shamt_s = {1'b0, code_q} + {{SHIFT_W{1'b0}}, 1'b1};
    wide_s  = (WIDE_W'(ones_q) << shamt_s) >> STREAM_LOG;
  end

  always_comb begin
    code_d = code_q;
    ones_d = ones_q;
    bit_d  = bit_q;
    dout_d = dout_q;
    ovf_d  = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          code_d = (shift_in < FLOOR_CODE) ? FLOOR_CODE : shift_in;
          ones_d = '0;
          bit_d  = '0;
        end else begin
          code_d = code_q;
        end
      end
      S_ACCUM: begin
        if (bit_valid) begin
          bit_d  = bit_q + {{STREAM_LOG{1'b0}}, 1'b1};
          ones_d = ones_q + {{STREAM_LOG{1'b0}}, bit_in};
        end else begin
          bit_d  = bit_q;
        end
      end
      S_SCALE: begin
        if (wide_s > MAX_OUT) begin
          dout_d = '1;
          ovf_d  = 1'b1;
        end else begin
          dout_d = wide_s[DATA_WIDTH-1:0];
          ovf_d  = 1'b0;
        end
      end
      S_HOLD:  dout_d = dout_q;
      default: dout_d = dout_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      ones_q <= '0;
      bit_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      code_q <= code_d;
      ones_q <= ones_d;
      bit_q  <= bit_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_HOLD);
    dout      = dout_q;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_sc_denorm.sv
// Randomized self-checking bench for sc_denorm against an arithmetic reference model.
module tb_sc_denorm;

  localparam int N  = 256;
  localparam int KF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] shift_in = 3'd0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       busy;
  logic [7:0] dout;
  logic       overflow;
  logic       out_valid;
  logic       out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  bit bits[N];

  sc_denorm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .shift_in  (shift_in),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .busy      (busy),
    .dout      (dout),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int count_ones();
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(bits[i]);
    return n;
  endfunction

  // Real-valued meaning: ones/N * 2^(code+1), floored and saturated to 8 bits
  function automatic void ref_result(input int sh, input int ones, output int val, output int ovf);
    int code;
    int full;
    code = (sh < KF - 1) ? KF - 1 : sh;
    full = (ones * (2 ** (code + 1))) / N;
    ovf  = (full > 255) ? 1 : 0;
    val  = (full > 255) ? 255 : full;
  endfunction

  task automatic fill_exact(input int n_ones);
    bit t;
    int j;
    for (int i = 0; i < N; i++) bits[i] = (i < n_ones);
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = bits[i]; bits[i] = bits[j]; bits[j] = t;
    end
  endtask

  task automatic do_conv(input int sh, input int gap_mode, input int hold_wait, input bit poke);
    int ev, eo, cyc, idx;
    bit v;
    ref_result(sh, count_ones(), ev, eo);
    @(negedge clk);
    start = 1'b1; shift_in = sh[2:0]; bit_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; shift_in = 3'($urandom_range(0, 7));
    cyc = 1;
    chk("busy_rise", busy, 1);
    idx = 0;
    while (idx < N) begin
      if (gap_mode == 0)      v = 1'b1;
      else if (gap_mode == 1) v = (cyc % 2 == 0);
      else                    v = 1'($urandom_range(0, 1));
      bit_valid = v;
      bit_in = v ? bits[idx] : 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (v) idx++;
    end
    bit_valid = 1'b1; bit_in = 1'b1;
    chk("scale_not_valid", out_valid, 0);
    @(negedge clk);
    cyc++;
    chk("valid_after_last", out_valid, 1);
    if (gap_mode == 0) chk("latency", cyc, 258);
    chk("dout", dout, ev);
    chk("overflow", overflow, eo);
    for (int i = 0; i < hold_wait; i++) begin
      start = poke && (i == 1);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_dout", dout, ev);
    end
    start = poke;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0; bit_valid = 1'b0;
    chk("busy_fall", busy, 0);
    chk("valid_fall", out_valid, 0);
    chk("dout_kept", dout, ev);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    fill_exact(128); do_conv(7, 0, 0, 1'b0);
    fill_exact(256); do_conv(3, 0, 0, 1'b0);
    fill_exact(256); do_conv(7, 0, 0, 1'b0);
    fill_exact(64);  do_conv(1, 1, 0, 1'b0);
    fill_exact(200); do_conv(5, 0, 5, 1'b1);

    // Abort a conversion after 100 bits
    @(negedge clk);
    start = 1'b1; shift_in = 3'd7;
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    repeat (100) @(negedge clk);
    bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_dout", dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fill_exact(255); do_conv(7, 0, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      fill_exact($urandom_range(0, N));
      do_conv($urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
